// File: rtl/ds18b20_pkg.sv
// DS18B20 controller shared types: FSM states, 1-Wire engine command codes,
// ROM/function command bytes and counter widths.
package ds18b20_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT1,
    ST_SKIP1,
    ST_CONVT,
    ST_WAIT,
    ST_INIT2,
    ST_SKIP2,
    ST_RDSCR,
    ST_READ,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_INIT = 2'd1,
    CMD_WR   = 2'd2,
    CMD_RD   = 2'd3
  } cmd_e;

  localparam logic [7:0] ROM_SKIP = 8'hCC;
  localparam logic [7:0] FN_CONVT = 8'h44;
  localparam logic [7:0] FN_RDSCR = 8'hBE;

  // Watchdog spans 2x the conversion wait, which needs one more bit
  localparam int CNT_W = 26;
  localparam int WDG_W = 27;

  function automatic cmd_e state_cmd(state_e s);
    unique case (s)
      ST_INIT1, ST_INIT2:           return CMD_INIT;
      ST_SKIP1, ST_SKIP2,
      ST_CONVT, ST_RDSCR:           return CMD_WR;
      ST_READ:                      return CMD_RD;
      default:                      return CMD_NONE;
    endcase
  endfunction

  function automatic logic [7:0] state_byte(state_e s);
    unique case (s)
      ST_CONVT: return FN_CONVT;
      ST_RDSCR: return FN_RDSCR;
      default:  return ROM_SKIP;
    endcase
  endfunction

endpackage

// File: rtl/ds18b20_wait_cnt.sv
// Loadable saturating down-counter; done pulses on the last enabled count.
// Used for both the conversion wait and the watchdog.
module ds18b20_wait_cnt #(
  parameter int W = 26
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = en && (cnt_q == W'(1));

endmodule

// File: rtl/ds18b20_ctrl.sv
// DS18B20 measurement sequencer driving a 1-Wire engine.
// Define DS18B20_PRESENCE_CHK_EN to abort on a missing presence pulse.
module ds18b20_ctrl
  import ds18b20_pkg::*;
#(
  parameter int CONV_WAIT = 37_500_000,
  parameter bit AUTO_RUN  = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [1:0]  cmd,
  output logic [7:0]  data,
  input  logic        end_init,
  input  logic        end_bit,
  input  logic [2:0]  cmd_ok,
  input  logic [15:0] rec_data,
  output logic [15:0] temp_raw,
  output logic        temp_vld,
  output logic        busy,
  output logic        err_nopres
);

  localparam logic [CNT_W-1:0] WAIT_VAL = CNT_W'(CONV_WAIT);
  localparam logic [WDG_W-1:0] WDG_VAL  = WDG_W'(2 * CONV_WAIT);

  state_e      state_q, state_d;
  logic [1:0]  cmd_q, cmd_d;
  logic [7:0]  data_q, data_d;
  logic [15:0] temp_raw_q, temp_raw_d;
  logic        temp_vld_q, temp_vld_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        wait_done, wdg_done;
  logic        pres_fail, nopres;
  logic        unused_ok;

  assign unused_ok = ^cmd_ok[1:0];

`ifdef DS18B20_PRESENCE_CHK_EN
  assign pres_fail = end_init && !cmd_ok[0];
`else
  assign pres_fail = 1'b0;
`endif

  ds18b20_wait_cnt #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ST_CONVT && end_bit),
    .load_val (WAIT_VAL),
    .en       (state_q == ST_WAIT),
    .done     (wait_done)
  );

  ds18b20_wait_cnt #(.W(WDG_W)) u_wdg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ST_IDLE && state_d != ST_IDLE),
    .load_val (WDG_VAL),
    .en       (state_q != ST_IDLE),
    .done     (wdg_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NONE;
      data_q     <= '0;
      temp_raw_q <= '0;
      temp_vld_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      temp_raw_q <= temp_raw_d;
      temp_vld_q <= temp_vld_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    nopres  = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start || AUTO_RUN) state_d = ST_INIT1;
      ST_INIT1: begin
        if (pres_fail) begin
          state_d = ST_IDLE;
          nopres  = 1'b1;
        end else if (end_init) begin
          state_d = ST_SKIP1;
        end
      end
      ST_SKIP1: if (end_bit) state_d = ST_CONVT;
      ST_CONVT: if (end_bit) state_d = ST_WAIT;
      ST_WAIT:  if (wait_done) state_d = ST_INIT2;
      ST_INIT2: begin
        if (pres_fail) begin
          state_d = ST_IDLE;
          nopres  = 1'b1;
        end else if (end_init) begin
          state_d = ST_SKIP2;
        end
      end
      ST_SKIP2: if (end_bit) state_d = ST_RDSCR;
      ST_RDSCR: if (end_bit) state_d = ST_READ;
      ST_READ:  if (cmd_ok[2]) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Watchdog overrides every other transition
    if (wdg_done) state_d = ST_IDLE;
  end

  always_comb begin
    cmd_d      = CMD_NONE;
    data_d     = data_q;
    temp_raw_d = temp_raw_q;
    temp_vld_d = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    err_d      = wdg_done || nopres;
    if (state_d != state_q) begin
      cmd_d = state_cmd(state_d);
      if (state_cmd(state_d) == CMD_WR) data_d = state_byte(state_d);
    end
    if (state_q == ST_READ && state_d == ST_DONE) begin
      temp_raw_d = rec_data;
      temp_vld_d = 1'b1;
    end
  end

  assign cmd        = cmd_q;
  assign data       = data_q;
  assign temp_raw   = temp_raw_q;
  assign temp_vld   = temp_vld_q;
  assign busy       = busy_q;
  assign err_nopres = err_q;

endmodule

// File: doc/ds18b20_ctrl.md
DS18B20_CTRL -- requirements
Module: ds18b20_ctrl

Interface
REQ-001 Parameter CONV_WAIT, default 37_500_000, is the conversion wait in clk cycles (750 ms at 50 MHz).
REQ-002 Parameter AUTO_RUN, default 1'b0; when 1, a new measurement starts automatically after each DONE.
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 start  in  1  single-cycle request to run one measurement; ignored while busy.
REQ-006 cmd  out  2  command to the 1-Wire engine: 0 none, 1 init, 2 write byte, 3 read 16 bits.
REQ-007 data  out  8  byte to write; stable from the cmd pulse until end_bit.
REQ-008 end_init  in  1  init slot finished (pulse).
REQ-009 end_bit  in  1  8-bit slot group finished (pulse).
REQ-010 cmd_ok  in  3  [0] presence seen, [1] byte written, [2] 16 bits read; sampled as pulses.
REQ-011 rec_data  in  16  scratchpad bytes 0..1 (LSB first), valid when cmd_ok[2]=1.
REQ-012 temp_raw  out  16  last temperature word, 1/16 degC two's complement.
REQ-013 temp_vld  out  1  one-cycle pulse when temp_raw updates.
REQ-014 busy  out  1  high from acceptance of start until return to IDLE.
REQ-015 err_nopres  out  1  one-cycle pulse on an init with no presence.

Function
REQ-016 The FSM SHALL have states IDLE, INIT1, SKIP1, CONVT, WAIT, INIT2, SKIP2, RDSCR, READ, DONE.
REQ-017 IDLE->INIT1 on start=1 (or immediately when AUTO_RUN=1); busy rises the next cycle.
REQ-018 On entering each of INIT1/SKIP1/CONVT/INIT2/SKIP2/RDSCR/READ, cmd SHALL be driven non-zero for exactly one cycle, then 0.
REQ-019 INIT1/INIT2: cmd=1; leave on end_init (to SKIP1/SKIP2 respectively).
REQ-020 SKIP1/SKIP2: cmd=2, data=8'hCC; CONVT: cmd=2, data=8'h44; RDSCR: cmd=2, data=8'hBE; each leaves on end_bit.
REQ-021 Transitions: SKIP1->CONVT->WAIT; WAIT->INIT2 after exactly CONV_WAIT cycles; SKIP2->RDSCR->READ.
REQ-022 READ: cmd=3; on cmd_ok[2]=1, latch temp_raw<=rec_data and go to DONE.
REQ-023 DONE: pulse temp_vld for one cycle, then go to IDLE.
REQ-024 The wait counter SHALL be 26 bits, cleared on entering WAIT, and SHALL not wrap.
REQ-025 start during busy SHALL be ignored, not queued.
REQ-026 Outside an issue cycle cmd=0; data SHALL hold its last value.
REQ-027 A watchdog of 2*CONV_WAIT cycles in any non-IDLE state SHALL force IDLE with a err_nopres pulse.

Reset
REQ-028 On rst_n=0: state=IDLE, cmd=0, data=0, temp_raw=0, temp_vld=0, busy=0, err_nopres=0, all counters 0.
REQ-029 Reset asserted mid-measurement SHALL abort immediately; no temp_vld is produced.

Configuration
REQ-030 Macro DS18B20_PRESENCE_CHK_EN defined: at end_init, cmd_ok[0]=0 pulses err_nopres and returns to IDLE, and busy drops.
REQ-031 Macro DS18B20_PRESENCE_CHK_EN undefined: cmd_ok[0] is ignored, the sequence always proceeds, and err_nopres comes only from the watchdog.

Structure
REQ-032 Shared package ds18b20_pkg SHALL hold the state enum, the ROM/function command bytes (CC, 44, BE) and the cmd encodings 0..3.
REQ-033 One sub-module, ds18b20_wait_cnt (loadable down-counter with done pulse), serves both WAIT and the watchdog.

Verification
REQ-034 Scenario 1: start with a 1-Wire engine model (presence OK, rec_data=16'h0191) -> cmd sequence 1,2(CC),2(44),1,2(CC),2(BE),3; temp_raw=16'h0191; one temp_vld.
REQ-035 Scenario 2: measure WAIT duration with CONV_WAIT=100 -> cycles from CONVT end_bit to INIT2 cmd pulse = 100 (+-1 documented edge).
REQ-036 Scenario 3: macro defined, cmd_ok[0]=0 at first end_init -> err_nopres pulse, busy=0, no cmd=2 issued; macro undefined -> sequence continues.
REQ-037 Scenario 4: start pulsed again during WAIT -> no effect; exactly one temp_vld.
REQ-038 Scenario 5: rst_n low during RDSCR -> all outputs at reset values next cycle; no temp_vld.
REQ-039 Scenario 6: AUTO_RUN=1, rec_data=16'hFF5E -> back-to-back measurements, temp_raw=16'hFF5E (-10.125 degC) per run.
